mat_pos_serializer: RTL and testbench

Reads the packed feature-point address bus produced by the matching address register bank (16 × 15-bit addresses, 240 bits) and streams the addresses out one per handshake to downstream consumers (frame-memory readback, coordinate transmitter). Sits directly after the address register bank in the matching path. It turns the level-qualified parallel snapshot into a valid/ready stream with index, last-beat and done indications. It also flags match events it had to drop while busy.

---
 rtl/mat_pkg.sv | 26 ++
 rtl/mat_rise_det.sv | 25 ++
 rtl/mat_pos_serializer.sv | 152 +++++++++++++++
 tb/tb_mat_pos_serializer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the feature-point address serializer.
//   ADDR_W    width of one feature-point address
//   N_POS     number of addresses in the packed bus
//   IDX_W     width of an entry index
//   mat_state_e  serializer FSM states
//   mat_entry    extracts entry i from the packed bus (entry 0 sits in the MSBs)
package mat_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned N_POS  = 16;
  localparam int unsigned IDX_W  = $clog2(N_POS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } mat_state_e;

  function automatic logic [ADDR_W-1:0] mat_entry(input logic [ADDR_W*N_POS-1:0] pos,
                                                  input logic [IDX_W-1:0]        i);
    int unsigned k;
    k = N_POS - 1 - int'(i);
    return pos[k*ADDR_W +: ADDR_W];
  endfunction

endpackage

// File: rtl/mat_rise_det.sv
// Registered rising-edge detector for the isMatching level.
//   clk      clock
//   rst_n    asynchronous active-low reset (history register clears to 0)
//   level_i  level input
//   rise_o   high while level_i is high and was low at the previous edge
module mat_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/mat_pos_serializer.sv
// Serializes a snapshot of the packed feature-point address bus into a valid/ready stream.
// A rising edge of isMatching in IDLE latches the whole bus; entries are then emitted one per
// handshake with index and last-beat flags, followed by a one-cycle done pulse. Match events that
// arrive while busy are dropped and recorded in the sticky overrun flag.
//   clk, rst_n   clock, asynchronous active-low reset
//   position     packed addresses, entry 0 in the MSBs
//   isMatching   level qualifying position
//   out_addr/out_idx/out_valid/out_last, out_ready   output stream
//   busy, done   status (busy in SEND/DONE, done one cycle after the final beat)
//   overrun, clr_ovr   sticky dropped-event flag and its synchronous clear
// Build option: define MAT_SKIP_ZERO_EN to skip zero (unwritten) entries.
// ADDR_W/N_POS must match the mat_pkg values; the entry helper is sized by the package.
module mat_pos_serializer #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned N_POS  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W*N_POS-1:0]   position,
  input  logic                      isMatching,
  output logic [ADDR_W-1:0]         out_addr,
  output logic [mat_pkg::IDX_W-1:0] out_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun,
  input  logic                      clr_ovr
);

  import mat_pkg::*;

  mat_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ADDR_W*N_POS-1:0] shadow_q, shadow_d;
  logic                    ovr_q, ovr_d;
  logic                    match_evt;
  logic                    cur_nz;   // current entry is to be emitted
  logic                    last_c;   // current entry is the final one to emit
  logic                    start_send;

  mat_rise_det u_rise_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (isMatching),
    .rise_o  (match_evt)
  );

`ifdef MAT_SKIP_ZERO_EN
  logic [N_POS-1:0] mask_q, mask_d, pos_mask, mask_above;

  always_comb begin
    pos_mask = '0;
    for (int i = 0; i < int'(N_POS); i++) begin
      pos_mask[i] = |mat_entry(position, IDX_W'(i));
    end
  end

  assign mask_above = mask_q >> idx_q;
  assign cur_nz     = mask_q[idx_q];
  assign last_c     = (mask_above[N_POS-1:1] == '0);
  // All-zero snapshot has nothing to emit, so SEND is bypassed.
  assign start_send = (pos_mask != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end
`else
  assign cur_nz     = 1'b1;
  assign last_c     = (idx_q == IDX_W'(N_POS - 1));
  assign start_send = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    ovr_d     = clr_ovr ? 1'b0 : ovr_q;
`ifdef MAT_SKIP_ZERO_EN
    mask_d    = mask_q;
`endif
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_addr  = '0;
    out_idx   = idx_q;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (match_evt) begin
          shadow_d = position;
          idx_d    = '0;
`ifdef MAT_SKIP_ZERO_EN
          mask_d   = pos_mask;
`endif
          state_d  = start_send ? ST_SEND : ST_DONE;
        end
      end
      ST_SEND: begin
        busy      = 1'b1;
        out_valid = cur_nz;
        out_last  = cur_nz & last_c;
        out_addr  = cur_nz ? mat_entry(shadow_q, idx_q) : '0;
        if (match_evt) begin
          ovr_d = 1'b1;  // set wins over clr_ovr
        end
        if (!cur_nz) begin
          // A skipped entry always has a later emitted entry, so this cannot wrap.
          idx_d = idx_q + 1'b1;
        end else if (out_ready) begin
          if (last_c) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
        if (match_evt) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      ovr_q    <= ovr_d;
    end
  end

  assign overrun = ovr_q;

endmodule

// File: tb/tb_mat_pos_serializer.sv
module tb_mat_pos_serializer;

  localparam int AW = 15;
  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW*NP-1:0] position = '0;
  logic          isMatching = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr_ovr = 1'b0;
  logic [AW-1:0] out_addr;
  logic [3:0]    out_idx;
  logic          out_valid, out_last, busy, done, overrun;

  int checks = 0;
  int passes = 0;

  logic [AW-1:0] q_addr[$];
  logic [3:0]    q_idx[$];
  logic          q_last[$];
  logic [AW-1:0] entries[NP];

  always #5 clk = ~clk;

  mat_pos_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .position   (position),
    .isMatching (isMatching),
    .out_addr   (out_addr),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr)
  );

  // Drive position from entries[] and push the expected beats.
  task automatic load_snapshot();
    int last_i;
    last_i = NP - 1;
`ifdef MAT_SKIP_ZERO_EN
    last_i = -1;
    for (int i = 0; i < NP; i++) if (entries[i] != 0) last_i = i;
`endif
    for (int i = 0; i < NP; i++) begin
      position[(NP-1-i)*AW +: AW] = entries[i];
`ifdef MAT_SKIP_ZERO_EN
      if (entries[i] == 0) continue;
`endif
      q_addr.push_back(entries[i]);
      q_idx.push_back(4'(i));
      q_last.push_back(i == last_i);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after the sampling edge.
  task automatic fire_event();
    isMatching = 1'b1;
    @(posedge clk); #1;
    isMatching = 1'b0;
  endtask

  // Consume beats against the scoreboard; returns at posedge+1 after stop_after beats or
  // in the cycle after done.
  task automatic drain(input bit toggle, input int stop_after, input int budget,
                       output int beats, output int done_cycle);
    int cyc;
    bit stalled;
    logic [AW-1:0] s_addr;
    logic [3:0] s_idx;
    cyc = 0; beats = 0; done_cycle = -1; stalled = 0; s_addr = '0; s_idx = '0;
    while (cyc < budget) begin
      cyc++;
      if (done) begin
        done_cycle = cyc;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1)
          $display("FAIL done_cycle_flags: valid=%b busy=%b want valid=0 busy=1", out_valid, busy);
        else passes++;
        @(posedge clk); #1;
        return;
      end
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_addr !== s_addr || out_idx !== s_idx)
          $display("FAIL stall_stable: valid=%b addr=%0d idx=%0d want valid=1 addr=%0d idx=%0d",
                   out_valid, out_addr, out_idx, s_addr, s_idx);
        else passes++;
      end
      stalled = 0;
      if (out_valid) begin
        checks++;
        if (q_addr.size() == 0) begin
          $display("FAIL unexpected_beat: addr=%0d idx=%0d want no beat", out_addr, out_idx);
        end else if (out_addr !== q_addr[0] || out_idx !== q_idx[0] || out_last !== q_last[0]) begin
          $display("FAIL beat: addr=%0d idx=%0d last=%b want addr=%0d idx=%0d last=%b",
                   out_addr, out_idx, out_last, q_addr[0], q_idx[0], q_last[0]);
        end else passes++;
        if (out_ready) begin
          if (q_addr.size() != 0) begin
            void'(q_addr.pop_front()); void'(q_idx.pop_front()); void'(q_last.pop_front());
          end
          beats++;
        end else begin
          stalled = 1; s_addr = out_addr; s_idx = out_idx;
        end
      end
      @(posedge clk); #1;
      if (stop_after > 0 && beats == stop_after) return;
    end
    checks++;
    $display("FAIL drain_timeout: beats=%0d after %0d cycles want done pulse", beats, budget);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, busy, done, overrun} !== 5'b0 || out_addr !== '0 || out_idx !== '0)
      $display("FAIL reset_values: v=%b l=%b b=%b d=%b o=%b addr=%0d idx=%0d want all 0",
               out_valid, out_last, busy, done, overrun, out_addr, out_idx);
    else passes++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream_full();
    int beats, dc;
    for (int i = 0; i < NP; i++) entries[i] = AW'(100 + i);
    load_snapshot();
    fire_event();
    position = '1;  // later bus changes must not reach the stream
    drain(1'b0, 0, 40, beats, dc);
    checks++;
    if (beats != 16 || dc != 17) $display("FAIL full_timing: beats=%0d done_cycle=%0d want 16/17", beats, dc);
    else passes++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || q_addr.size() != 0)
      $display("FAIL full_after: busy=%b done=%b valid=%b left=%0d want 0/0/0/0",
               busy, done, out_valid, q_addr.size());
    else passes++;
  endtask

  task automatic test_stall();
    int beats, dc;
    for (int i = 0; i < NP; i++) entries[i] = AW'(100 + i);
    load_snapshot();
    fire_event();
    drain(1'b1, 0, 60, beats, dc);
    checks++;
    if (beats != 16 || dc != 33) $display("FAIL stall_timing: beats=%0d done_cycle=%0d want 16/33", beats, dc);
    else passes++;
    out_ready = 1'b1;
  endtask

  task automatic test_overrun();
    int b1, b2, b3, dc;
    for (int i = 0; i < NP; i++) entries[i] = AW'(100 + i);
    load_snapshot();
    fire_event();
    drain(1'b0, 5, 40, b1, dc);
    checks++;
    if (overrun !== 1'b0) $display("FAIL ovr_pre: overrun=%b want 0", overrun);
    else passes++;
    isMatching = 1'b1;
    drain(1'b0, 1, 40, b2, dc);
    isMatching = 1'b0;
    checks++;
    if (overrun !== 1'b1) $display("FAIL ovr_set: overrun=%b want 1", overrun);
    else passes++;
    drain(1'b0, 0, 40, b3, dc);
    checks++;
    if (b1 + b2 + b3 != 16 || overrun !== 1'b1 || busy !== 1'b0)
      $display("FAIL ovr_stream: beats=%0d overrun=%b busy=%b want 16/1/0", b1 + b2 + b3, overrun, busy);
    else passes++;
    // Earliest legal event (IDLE) together with a clear.
    for (int i = 0; i < NP; i++) entries[i] = AW'(300 + i);
    load_snapshot();
    clr_ovr = 1'b1;
    fire_event();
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0 || out_valid !== 1'b1 || out_idx !== 4'd0)
      $display("FAIL ovr_clr_restart: overrun=%b valid=%b idx=%0d want 0/1/0", overrun, out_valid, out_idx);
    else passes++;
    drain(1'b0, 2, 40, b1, dc);
    isMatching = 1'b1;
    clr_ovr = 1'b1;
    drain(1'b0, 1, 40, b2, dc);
    isMatching = 1'b0;
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b1) $display("FAIL ovr_set_wins: overrun=%b want 1", overrun);
    else passes++;
    drain(1'b0, 0, 40, b3, dc);
    checks++;
    if (b1 + b2 + b3 != 16 || q_addr.size() != 0)
      $display("FAIL ovr_stream2: beats=%0d left=%0d want 16/0", b1 + b2 + b3, q_addr.size());
    else passes++;
    clr_ovr = 1'b1;
    @(posedge clk); #1;
    clr_ovr = 1'b0;
  endtask

  task automatic test_held_high();
    int beats, dc, extra;
    for (int i = 0; i < NP; i++) entries[i] = AW'($urandom_range(1, 32767));
    load_snapshot();
    isMatching = 1'b1;
    @(posedge clk); #1;
    drain(1'b0, 0, 40, beats, dc);
    extra = 0;
    repeat (22) begin
      if (out_valid || busy) extra++;
      @(posedge clk); #1;
    end
    checks++;
    if (beats != 16 || extra != 0 || overrun !== 1'b0)
      $display("FAIL held_high: beats=%0d extra=%0d overrun=%b want 16/0/0", beats, extra, overrun);
    else passes++;
    isMatching = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int beats, dc;
    for (int i = 0; i < NP; i++) entries[i] = AW'(100 + i);
    load_snapshot();
    fire_event();
    drain(1'b0, 3, 40, beats, dc);
    isMatching = 1'b1;
    drain(1'b0, 1, 40, beats, dc);
    isMatching = 1'b0;
    drain(1'b0, 3, 40, beats, dc);
    checks++;
    if (overrun !== 1'b1 || out_idx !== 4'd7)
      $display("FAIL rst_mid_pre: overrun=%b idx=%0d want 1/7", overrun, out_idx);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, overrun, done, out_last} !== 5'b0 || out_addr !== '0 || out_idx !== '0)
      $display("FAIL rst_mid: v=%b b=%b o=%b d=%b l=%b addr=%0d idx=%0d want all 0",
               out_valid, busy, overrun, done, out_last, out_addr, out_idx);
    else passes++;
    q_addr.delete(); q_idx.delete(); q_last.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) entries[i] = AW'(200 + i);
    load_snapshot();
    fire_event();
    drain(1'b0, 0, 40, beats, dc);
    checks++;
    if (beats != 16 || dc != 17) $display("FAIL rst_restart: beats=%0d done_cycle=%0d want 16/17", beats, dc);
    else passes++;
  endtask

`ifdef MAT_SKIP_ZERO_EN
  task automatic test_skip_zero();
    int beats, dc;
    for (int i = 0; i < NP; i++) entries[i] = '0;
    entries[3] = 15'h1111; entries[9] = 15'h2222; entries[15] = 15'h3333;
    load_snapshot();
    fire_event();
    drain(1'b0, 0, 40, beats, dc);
    checks++;
    if (beats != 3 || dc != 17) $display("FAIL skip_sparse: beats=%0d done_cycle=%0d want 3/17", beats, dc);
    else passes++;
    for (int i = 0; i < NP; i++) entries[i] = '0;
    load_snapshot();
    fire_event();
    drain(1'b0, 0, 40, beats, dc);
    checks++;
    if (beats != 0 || dc != 1) $display("FAIL skip_all_zero: beats=%0d done_cycle=%0d want 0/1", beats, dc);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_stream_full();
    test_stall();
    test_overrun();
    test_held_high();
    test_reset_mid();
`ifdef MAT_SKIP_ZERO_EN
    test_skip_zero();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
